// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider and display-scan timebase.
// Emits a tick strobe, a 50% duty newClock and a digit scan select from clk5.
module prog_clock_divider #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 624,
  parameter int SCAN_DIGITS = 4
) (
  input  logic                           clk5,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [WIDTH-1:0]               div_val,
  input  logic                           div_load,
  output logic                           div_busy,
  output logic                           tick,
  output logic                           newClock,
  output logic [$clog2(SCAN_DIGITS)-1:0] digit_sel,
  output logic [SCAN_DIGITS-1:0]         digit_an
);

  localparam int                     SELW      = $clog2(SCAN_DIGITS);
  localparam logic [SELW-1:0]        SEL_LAST  = SELW'(SCAN_DIGITS - 1);
  localparam logic [SCAN_DIGITS-1:0] AN_RESET  = ~SCAN_DIGITS'(1);
  localparam logic [WIDTH-1:0]       DIV_RESET = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0]       count;
  logic [WIDTH-1:0]       div_active;
  logic [WIDTH-1:0]       div_pending;
  logic                   terminal;
  logic [SELW-1:0]        sel_next;
  logic [SCAN_DIGITS-1:0] an_next;

  always_comb begin
    terminal = (count == div_active);
    sel_next = (digit_sel == SEL_LAST) ? '0 : digit_sel + SELW'(1);
    an_next  = '1;
    for (int unsigned i = 0; i < SCAN_DIGITS; i++) begin
      an_next[i] = (sel_next != SELW'(i));
    end
  end

  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      div_active  <= DIV_RESET;
      div_pending <= '0;
      div_busy    <= 1'b0;
      tick        <= 1'b0;
      newClock    <= 1'b0;
      digit_sel   <= '0;
      digit_an    <= AN_RESET;
    end else begin
      // Load capture and transfer are mutually exclusive on div_busy.
      if (div_load && !div_busy) begin
        div_pending <= div_val;
        div_busy    <= 1'b1;
      end
      if (!enable) begin
        tick <= 1'b0;
        if (div_busy) begin
          div_active <= div_pending;
          count      <= '0;
          div_busy   <= 1'b0;
        end
      end else if (terminal) begin
        count     <= '0;
        tick      <= 1'b1;
        newClock  <= ~newClock;
        digit_sel <= sel_next;
        digit_an  <= an_next;
        // The finishing period used the old divisor, so no runt pulse.
        if (div_busy) begin
          div_active <= div_pending;
          div_busy   <= 1'b0;
        end
      end else begin
        count <= count + WIDTH'(1);
        tick  <= 1'b0;
      end
    end
  end

endmodule
